// File: rtl/pc_fetch_ctrl.sv
// PC/fetch sequencing for the IF stage: boot hold, redirect resolution with
// pending capture while imem is busy, hazard stalls and a stall-cycle counter.
module pc_fetch_ctrl #(
  parameter logic [31:0] RST_VAL     = 32'h0040_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_imem_ready,
  input  logic        i_load_use,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  output logic        o_pc_en,
  output logic [31:0] o_pc_next,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_misalign,
  output logic        o_booting,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR_WAIT} state_t;

  typedef struct packed {
    logic        vld;
    logic        mis;
    logic [31:0] addr;
  } redir_t;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  boot_cnt;
  logic [31:0] pend, pend_nxt;
  logic [31:0] raw_tgt;
  redir_t      rd;

  // Branch outranks jump; the fetch address is always word aligned.
  always_comb begin
    raw_tgt = i_branch_taken ? i_branch_target : i_jump_target;
    rd.vld  = i_branch_taken | i_jump;
    rd.mis  = rd.vld & (|raw_tgt[1:0]);
    rd.addr = {raw_tgt[31:2], 2'b00};
  end

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    o_pc_en       = 1'b0;
    o_pc_next     = i_pc + 32'd4;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_misalign    = 1'b0;
    o_booting     = 1'b0;
    case (state)
      BOOT: begin
        o_booting = 1'b1;
        o_pc_next = RST_VAL;
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (rd.vld) begin
          o_misalign    = rd.mis;
          o_pc_next     = rd.addr;
          o_if_id_flush = 1'b1;
          if (i_imem_ready) begin
            o_pc_en    = 1'b1;
            o_if_id_en = 1'b1;
          end else begin
            pend_nxt  = rd.addr;
            state_nxt = REDIR_WAIT;
          end
        end else if (i_imem_ready && !i_load_use) begin
          o_pc_en    = 1'b1;
          o_if_id_en = 1'b1;
        end
      end
      REDIR_WAIT: begin
        // Keep bubbling IF/ID until the redirect is actually fetched.
        o_if_id_flush = 1'b1;
        o_if_id_en    = 1'b1;
        o_misalign    = rd.mis;
        if (i_imem_ready) begin
          o_pc_en   = 1'b1;
          o_pc_next = rd.vld ? rd.addr : pend;
          state_nxt = RUN;
        end else begin
          o_pc_next = pend;
          if (rd.vld) pend_nxt = rd.addr;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pend        <= '0;
      o_stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (state == BOOT) boot_cnt <= boot_cnt + 8'd1;
      if (state != BOOT && !o_pc_en && o_stall_cnt != 16'hFFFF)
        o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_VAL = 32'h0040_0000;
  localparam int BOOT_CYCLES = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic        i_imem_ready, i_load_use, i_branch_taken, i_jump;
  logic [31:0] i_branch_target, i_jump_target;
  logic        o_pc_en, o_if_id_en, o_if_id_flush, o_misalign, o_booting;
  logic [31:0] o_pc_next;
  logic [15:0] o_stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  // model state: 0 boot, 1 run, 2 waiting for imem with a pending redirect
  int          m_mode;
  int          m_bcnt;
  logic [31:0] m_pend;
  int          m_stall;
  logic [31:0] m_pc;

  pc_fetch_ctrl #(.RST_VAL(RST_VAL), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_imem_ready(i_imem_ready),
    .i_load_use(i_load_use), .i_branch_taken(i_branch_taken), .i_jump(i_jump),
    .i_branch_target(i_branch_target), .i_jump_target(i_jump_target),
    .o_pc_en(o_pc_en), .o_pc_next(o_pc_next), .o_if_id_en(o_if_id_en),
    .o_if_id_flush(o_if_id_flush), .o_misalign(o_misalign), .o_booting(o_booting),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bcnt = 0; m_pend = 0; m_stall = 0; m_pc = RST_VAL;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance model at the edge.
  task automatic cyc(input logic br, input logic jmp, input logic [31:0] bt,
                     input logic [31:0] jt, input logic rdy, input logic lu);
    logic        redir, e_en, e_iden, e_fl, e_mis, c_next, c_iden;
    logic [31:0] tgt, e_next;
    i_pc = m_pc; i_branch_taken = br; i_jump = jmp; i_branch_target = bt;
    i_jump_target = jt; i_imem_ready = rdy; i_load_use = lu;
    #2;
    redir = br | jmp;
    tgt   = br ? bt : jt;
    e_en = 0; e_iden = 0; e_fl = 0; e_mis = 0; e_next = RST_VAL; c_next = 1; c_iden = 1;
    if (m_mode != 0) e_mis = redir && (tgt % 4 != 0);
    if (m_mode == 1) begin
      if (redir && rdy) begin
        e_en = 1; e_iden = 1; e_fl = 1; e_next = tgt - (tgt % 4);
      end else if (redir) begin
        e_fl = 1; c_next = 0; c_iden = 0;
      end else if (!rdy || lu) begin
        c_next = 0;
      end else begin
        e_en = 1; e_iden = 1; e_next = m_pc + 32'd4;
      end
    end else if (m_mode == 2) begin
      e_fl = 1; e_iden = 1;
      e_en = rdy;
      e_next = (rdy && redir) ? tgt - (tgt % 4) : m_pend;
    end
    chk("pc_en", 32'(o_pc_en), 32'(e_en));
    chk("flush", 32'(o_if_id_flush), 32'(e_fl));
    chk("misalign", 32'(o_misalign), 32'(e_mis));
    chk("booting", 32'(o_booting), 32'(m_mode == 0));
    chk("stall_cnt", 32'(o_stall_cnt), 32'(m_stall));
    if (c_next) chk("pc_next", o_pc_next, e_next);
    if (c_iden) chk("if_id_en", 32'(o_if_id_en), 32'(e_iden));
    if (m_mode != 0 && !e_en && m_stall < 65535) m_stall++;
    if (e_en) m_pc = e_next;
    case (m_mode)
      0: if (m_bcnt == BOOT_CYCLES - 1) m_mode = 1; else m_bcnt++;
      1: if (redir && !rdy) begin m_mode = 2; m_pend = tgt - (tgt % 4); end
      default: if (rdy) m_mode = 1; else if (redir) m_pend = tgt - (tgt % 4);
    endcase
    @(posedge i_clk);
    #1;
  endtask

  task automatic seq(input logic rdy, input logic lu);
    cyc(0, 0, 0, 0, rdy, lu);
  endtask

  initial begin
    i_rst_n = 0; i_pc = RST_VAL; i_imem_ready = 1; i_load_use = 1;
    i_branch_taken = 1; i_jump = 1; i_branch_target = 32'h0000_1003; i_jump_target = 32'h3;
    model_reset();
    #3;
    // requests are ignored while reset holds the block in boot
    chk("rst_pc_en", 32'(o_pc_en), 0);
    chk("rst_pc_next", o_pc_next, RST_VAL);
    chk("rst_if_id_en", 32'(o_if_id_en), 0);
    chk("rst_flush", 32'(o_if_id_flush), 0);
    chk("rst_misalign", 32'(o_misalign), 0);
    chk("rst_booting", 32'(o_booting), 1);
    chk("rst_stall", 32'(o_stall_cnt), 0);
    @(negedge i_clk);
    i_rst_n = 1;

    // boot: two held cycles (with requests ignored), then sequential fetch
    cyc(1, 1, 32'h0000_1003, 32'h3, 1, 1);
    cyc(1, 0, 32'h0000_1000, 32'h0, 1, 0);
    chk("boot_pc_in", i_pc, RST_VAL);
    seq(1, 0);
    chk("boot_first_pc", m_pc, 32'h0040_0004);
    seq(1, 0);

    // load-use bubble then resume
    seq(1, 1);
    chk("lu_stall_cnt", 32'(o_stall_cnt), 1);
    seq(1, 0);

    // branch beats jump and load-use
    cyc(1, 1, 32'h0040_0100, 32'h0040_0800, 1, 1);
    chk("br_prio_pc", m_pc, 32'h0040_0100);

    // misaligned jump while imem busy for three cycles
    cyc(0, 1, 0, 32'h0040_0203, 0, 0);
    seq(0, 1);
    seq(0, 0);
    seq(1, 0);
    chk("redir_wait_pc", m_pc, 32'h0040_0200);
    seq(1, 0);

    // redirect overwritten while pending
    cyc(1, 0, 32'h0000_2000, 0, 0, 0);
    cyc(0, 1, 0, 32'h0000_3006, 0, 0);
    seq(1, 0);
    chk("overwrite_pc", m_pc, 32'h0000_3004);

    // wrap
    m_pc = 32'hFFFF_FFFC;
    seq(1, 0);
    chk("wrap_pc", m_pc, 32'h0);

    // async reset while a redirect is pending
    cyc(0, 1, 0, 32'h0000_7770, 0, 0);
    #1 i_rst_n = 0;
    #1;
    chk("mid_rst_booting", 32'(o_booting), 1);
    chk("mid_rst_pc_en", 32'(o_pc_en), 0);
    chk("mid_rst_pc_next", o_pc_next, RST_VAL);
    chk("mid_rst_flush", 32'(o_if_id_flush), 0);
    chk("mid_rst_if_id_en", 32'(o_if_id_en), 0);
    chk("mid_rst_stall", 32'(o_stall_cnt), 0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    for (int i = 0; i < 8; i++) seq(1, 0);
    chk("post_rst_pc", m_pc, RST_VAL + 32'd24);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);

    // saturation of the stall counter
    for (int i = 0; i < 70000; i++) seq(0, 0);
    chk("stall_sat", 32'(o_stall_cnt), 32'hFFFF);
    seq(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RST_VAL, default 32'h0040_0000, PC value driven during reset/boot.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, cycles PC is held after reset release; legal range 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_pc, input, 32, current PC register value.
REQ-007 SHALL have port i_imem_ready, input, 1, instruction memory accepts a fetch this cycle.
REQ-008 SHALL have port i_load_use, input, 1, load-use hazard stall request.
REQ-009 SHALL have ports i_branch_taken and i_jump, input, 1 each, redirect requests.
REQ-010 SHALL have ports i_branch_target and i_jump_target, input, 32 each, redirect addresses.
REQ-011 SHALL have port o_pc_en, output, 1, PC register enable.
REQ-012 SHALL have port o_pc_next, output, 32, PC register D input.
REQ-013 SHALL have ports o_if_id_en and o_if_id_flush, output, 1 each, IF/ID register enable and bubble insert.
REQ-014 SHALL have port o_misalign, output, 1, redirect target had bits [1:0] nonzero.
REQ-015 SHALL have ports o_booting, output, 1, and o_stall_cnt, output, 16, saturating stall-cycle counter.

Function
REQ-016 SHALL implement states BOOT, RUN, REDIR_WAIT; all outputs except o_stall_cnt combinational from state, pending register and inputs.
REQ-017 SHALL, in BOOT: o_pc_en=0, o_if_id_en=0, o_if_id_flush=0, o_pc_next=RST_VAL, o_booting=1; all requests ignored; boot counter increments; at count BOOT_CYCLES-1 go to RUN next edge.
REQ-018 SHALL resolve RUN priority: i_branch_taken > i_jump > !i_imem_ready > i_load_use > sequential.
REQ-019 SHALL form redirect target as selected target with bits [1:0] forced to 0; o_misalign=1 in any cycle a redirect is applied or captured with original bits [1:0] nonzero.
REQ-020 SHALL, in RUN with redirect and i_imem_ready=1: o_pc_en=1, o_pc_next=target, o_if_id_flush=1, o_if_id_en=1, remain RUN.
REQ-021 SHALL, in RUN with redirect and i_imem_ready=0: o_pc_en=0, o_if_id_flush=1, capture target into pending register, go to REDIR_WAIT.
REQ-022 SHALL, in RUN with no redirect and (i_imem_ready=0 or i_load_use=1): o_pc_en=0, o_if_id_en=0, o_if_id_flush=0, remain RUN.
REQ-023 SHALL, in RUN otherwise: o_pc_en=1, o_if_id_en=1, o_pc_next=i_pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 SHALL, in REDIR_WAIT: o_if_id_flush=1, o_if_id_en=1, i_load_use ignored; a new redirect overwrites pending (same priority).
REQ-025 SHALL, in REDIR_WAIT with i_imem_ready=1: o_pc_en=1, o_pc_next=new redirect target if present this cycle else pending, go to RUN; with i_imem_ready=0: o_pc_en=0, o_pc_next=pending.
REQ-026 SHALL increment o_stall_cnt each cycle outside BOOT with o_pc_en=0, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, on i_rst_n=0 at any time, immediately enter BOOT, clear boot counter, pending register (to 0) and o_stall_cnt; outputs become o_pc_en=0, o_pc_next=RST_VAL, o_if_id_en=0, o_if_id_flush=0, o_misalign=0, o_booting=1.
REQ-028 SHALL treat reset assertion during REDIR_WAIT as discarding the pending redirect.

Verification
REQ-029 SHALL cover boot: release reset, BOOT_CYCLES=2 -> o_pc_en=0 cycles 0-1, o_pc_en=1 with o_pc_next=32'h0040_0004 at cycle 2 (i_pc=32'h0040_0000).
REQ-030 SHALL cover load-use: i_load_use=1 one cycle in RUN -> o_pc_en=0, o_if_id_en=0, o_stall_cnt +1, then sequential resumes.
REQ-031 SHALL cover simultaneous branch+jump+load_use: branch_target=32'h0040_0100 -> o_pc_next=32'h0040_0100, o_if_id_flush=1, o_pc_en=1.
REQ-032 SHALL cover redirect with memory busy: jump to 32'h0040_0203, i_imem_ready=0 for 3 cycles -> o_misalign=1 at capture, o_pc_en=0 three cycles, then o_pc_next=32'h0040_0200, o_pc_en=1, back to RUN.
REQ-033 SHALL cover wrap and saturation: i_pc=32'hFFFF_FFFC -> o_pc_next=0; 70000 stall cycles -> o_stall_cnt=16'hFFFF.
REQ-034 SHALL cover async reset mid-REDIR_WAIT -> immediate BOOT outputs, pending never applied after release.
